bus_host_arbiter: RTL and testbench

- Round-robin arbiter that shares one req/gnt/rvalid device port (the bus host port into the simple-system interconnect) between NrHosts requesters, e.g. core data port plus a DMA or debug host.
- Grants at most one host per cycle and forwards that host's request downstream.
- Records the granted host ID in an in-order outstanding-response FIFO and routes each returning rvalid/rdata/err to the host that issued the request.
- Sits between the hosts and the bus host port.

---
 rtl/bus_host_arbiter.sv | 103 ++++++++++
 tb/tb_bus_host_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_host_arbiter.sv
// bus_host_arbiter: round-robin sharing of one req/gnt/rvalid device port among several hosts
module bus_host_arbiter #(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
    output logic [NrHosts-1:0]                host_err_o,
    output logic                              dev_req_o,
    input  logic                              dev_gnt_i,
    output logic [AddressWidth-1:0]           dev_addr_o,
    output logic                              dev_we_o,
    output logic [DataWidth/8-1:0]            dev_be_o,
    output logic [DataWidth-1:0]              dev_wdata_o,
    input  logic                              dev_rvalid_i,
    input  logic [DataWidth-1:0]              dev_rdata_i,
    input  logic                              dev_err_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                              protocol_err_o
);
    localparam int CW = $clog2(MaxOutstanding + 1);
    localparam int PW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
    localparam int IW = $clog2(NrHosts);
    localparam int BW = DataWidth / 8;

    logic [IW-1:0] rr, sel, head;
    logic [IW-1:0] ids [MaxOutstanding];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic          found, full, gnt, pop, perr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return PW'((32'(p) + 1) % MaxOutstanding);
    endfunction

    // First requesting host at or after the round-robin pointer; scanning backwards lets the earliest win
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = NrHosts - 1; i >= 0; i--) begin
            if (host_req_i[(32'(rr) + i) % NrHosts]) begin
                sel   = IW'((32'(rr) + i) % NrHosts);
                found = 1'b1;
            end
        end
    end

    assign full          = count == CW'(MaxOutstanding);
    assign dev_req_o     = rst_ni && found && !full;
    assign gnt           = dev_req_o && dev_gnt_i;
    assign host_gnt_o    = NrHosts'(gnt) << sel;
    assign dev_addr_o    = dev_req_o ? host_addr_i[sel*AddressWidth +: AddressWidth] : '0;
    assign dev_we_o      = dev_req_o && host_we_i[sel];
    assign dev_be_o      = dev_req_o ? host_be_i[sel*BW +: BW] : '0;
    assign dev_wdata_o   = dev_req_o ? host_wdata_i[sel*DataWidth +: DataWidth] : '0;
    assign pop           = dev_rvalid_i && count != '0;
    assign head          = ids[rp];
    assign host_rvalid_o = NrHosts'(pop) << head;
    assign host_err_o    = NrHosts'(pop && dev_err_i) << head;
    assign outstanding_o = count;
    assign protocol_err_o = perr;

    // Steer the response data only to the host owning the oldest outstanding entry
    always_comb begin
        host_rdata_o = '0;
        for (int h = 0; h < NrHosts; h++)
            host_rdata_o[h*DataWidth +: DataWidth] = host_rvalid_o[h] ? dev_rdata_i : '0;
    end

    // Occupancy, FIFO pointers, round-robin pointer and sticky spurious-response flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
            wp    <= '0;
            rp    <= '0;
            rr    <= '0;
            perr  <= 1'b0;
        end else begin
            count <= count + CW'(gnt) - CW'(pop);
            if (gnt) begin
                wp <= nxt(wp);
                rr <= IW'((32'(sel) + 1) % NrHosts);
            end
            if (pop) rp <= nxt(rp);
            if (dev_rvalid_i && count == '0) perr <= 1'b1;
        end
    end

    // ID storage needs no reset: entries are only read while counted as outstanding
    always_ff @(posedge clk_i) begin
        if (gnt) ids[wp] <= sel;
    end
endmodule

// File: tb/tb_bus_host_arbiter.sv
// tb_bus_host_arbiter: directed and random checks against a queue-based reference model
module tb_bus_host_arbiter;
    localparam int N = 3, DW = 32, AW = 32, MO = 2, BW = DW / 8;

    logic clk = 0, rst_n = 0;
    logic [N-1:0] req = '0, we = '0, gnt_o, rv_o, err_o;
    logic [N*AW-1:0] addr = '0;
    logic [N*BW-1:0] be = '0;
    logic [N*DW-1:0] wdata = '0, rdata_o;
    logic dev_req, dev_gnt = 0, dev_we, dev_rvalid = 0, dev_err = 0, perr_o;
    logic [AW-1:0] dev_addr;
    logic [BW-1:0] dev_be;
    logic [DW-1:0] dev_wdata, dev_rdata = '0;
    logic [1:0] outst;

    int q[$];
    int rr = 0;
    bit perr = 0;
    logic [N-1:0] last_gnt = '0;
    int nchk = 0, nfail = 0;

    bus_host_arbiter #(.NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .host_req_i(req), .host_gnt_o(gnt_o), .host_addr_i(addr),
        .host_we_i(we), .host_be_i(be), .host_wdata_i(wdata), .host_rvalid_o(rv_o),
        .host_rdata_o(rdata_o), .host_err_o(err_o), .dev_req_o(dev_req), .dev_gnt_i(dev_gnt),
        .dev_addr_o(dev_addr), .dev_we_o(dev_we), .dev_be_o(dev_be), .dev_wdata_o(dev_wdata),
        .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
        .outstanding_o(outst), .protocol_err_o(perr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_host(input int h);
        req[h] = 1'b1;
        addr[h*AW +: AW] = $urandom;
        wdata[h*DW +: DW] = $urandom;
        be[h*BW +: BW] = BW'($urandom);
        we[h] = 1'($urandom);
    endtask

    task automatic step();
        int sel;
        bit any, ereq, eg, epop;
        logic [N-1:0] egnt, erv, eerr;
        logic [N*DW-1:0] erd;
        #1;
        any = 0;
        sel = 0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[(rr + i) % N]) begin
                any = 1;
                sel = (rr + i) % N;
            end
        end
        ereq = any && q.size() < MO;
        eg = ereq && dev_gnt;
        egnt = eg ? N'(1 << sel) : '0;
        epop = dev_rvalid && q.size() > 0;
        erv = '0;
        eerr = '0;
        erd = '0;
        if (epop) begin
            erv[q[0]] = 1'b1;
            eerr[q[0]] = dev_err;
            erd[q[0]*DW +: DW] = dev_rdata;
        end
        chk("dev_req", dev_req, ereq);
        chk("host_gnt", gnt_o, egnt);
        chk("dev_addr", dev_addr, ereq ? addr[sel*AW +: AW] : '0);
        chk("dev_we", dev_we, ereq ? we[sel] : 1'b0);
        chk("dev_be", dev_be, ereq ? be[sel*BW +: BW] : '0);
        chk("dev_wdata", dev_wdata, ereq ? wdata[sel*DW +: DW] : '0);
        chk("host_rvalid", rv_o, erv);
        chk("host_rdata", rdata_o, erd);
        chk("host_err", err_o, eerr);
        chk("outstanding", outst, q.size());
        chk("protocol_err", perr_o, perr);
        last_gnt = egnt;
        @(posedge clk);
        if (dev_rvalid && q.size() == 0) perr = 1;
        if (epop) void'(q.pop_front());
        if (eg) begin
            q.push_back(sel);
            rr = (sel + 1) % N;
        end
        #1;
    endtask

    task automatic drain();
        req = '0;
        dev_gnt = 0;
        for (int k = 0; k < 2 * MO && q.size() > 0; k++) begin
            dev_rvalid = 1;
            dev_rdata = $urandom;
            dev_err = 1'($urandom);
            step();
        end
        dev_rvalid = 0;
        dev_err = 0;
    endtask

    initial begin
        req = '1;
        dev_gnt = 1;
        dev_rvalid = 1;
        #12;
        chk("rst_dev_req", dev_req, 1'b0);
        chk("rst_gnt", gnt_o, '0);
        chk("rst_rvalid", rv_o, '0);
        chk("rst_outstanding", outst, 0);
        chk("rst_perr", perr_o, 1'b0);
        @(negedge clk);
        req = '0;
        dev_gnt = 0;
        dev_rvalid = 0;
        rst_n = 1;
        @(posedge clk);
        #1;

        set_host(0);
        dev_gnt = 1;
        step();
        req = '0;
        dev_rvalid = 1;
        dev_rdata = 32'hDEADBEEF;
        step();
        dev_rvalid = 0;
        step();

        set_host(0);
        set_host(1);
        step();
        dev_rvalid = 1;
        for (int k = 0; k < 4; k++) begin
            dev_rdata = $urandom;
            step();
        end
        drain();

        set_host(0);
        set_host(1);
        dev_gnt = 1;
        for (int k = 0; k < 4; k++) step();
        dev_rvalid = 1;
        dev_rdata = 32'h1234_5678;
        step();
        dev_rvalid = 0;
        step();
        drain();

        set_host(1);
        dev_gnt = 0;
        for (int k = 0; k < 3; k++) step();
        dev_gnt = 1;
        step();
        drain();

        dev_rvalid = 1;
        step();
        dev_rvalid = 0;
        step();
        step();

        set_host(0);
        set_host(2);
        dev_gnt = 1;
        step();
        step();
        chk("pre_rst_outstanding", outst, 2);
        rst_n = 0;
        #1;
        q.delete();
        rr = 0;
        perr = 0;
        chk("async_outstanding", outst, 0);
        chk("async_gnt", gnt_o, '0);
        chk("async_dev_req", dev_req, 1'b0);
        chk("async_perr", perr_o, 1'b0);
        @(negedge clk);
        rst_n = 1;
        req = '0;
        @(posedge clk);
        #1;
        dev_rvalid = 1;
        step();
        dev_rvalid = 0;
        step();

        rst_n = 0;
        #1;
        perr = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 400; c++) begin
            for (int h = 0; h < N; h++) begin
                if (last_gnt[h]) begin
                    req[h] = 1'b0;
                    if ($urandom_range(0, 1) == 1) set_host(h);
                end else if (!req[h] && $urandom_range(0, 2) == 0) begin
                    set_host(h);
                end
            end
            dev_gnt = $urandom_range(0, 9) < 7;
            dev_rvalid = q.size() > 0 && $urandom_range(0, 1) == 1;
            dev_rdata = $urandom;
            dev_err = 1'($urandom);
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
